// File: rtl/data_sram_bridge_pkg.sv
// Shared defines for the data SRAM bridge: FSM encodings, bus size codes, captured-request layout.
package data_sram_bridge_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [1:0] DATA_SIZE_BYTE = 2'd0;
   localparam logic [1:0] DATA_SIZE_HALF = 2'd1;
   localparam logic [1:0] DATA_SIZE_WORD = 2'd2;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_req_t;

   // kseg0/kseg1 (0x8000_0000-0xBFFF_FFFF) map to physical by dropping the top three bits
   function automatic logic [31:0] kseg_map(input logic [31:0] va);
      if (va[31:30] == 2'b10) return {3'b000, va[28:0]};
      return va;
   endfunction

endpackage

// File: rtl/data_sram_bridge_if.sv
// MEM-stage and SRAM-like bus signals; master is the bridge, slave is the pipeline plus memory.
interface data_sram_bridge_if;
   logic        mem_en;
   logic [3:0]  mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_stall;
   logic        mem_adv;
   logic        flush;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;

   modport master (
      input  mem_en, mem_wen, mem_addr, mem_wdata, mem_adv, flush,
      input  data_addr_ok, data_data_ok, data_rdata,
      output mem_rdata, mem_stall,
      output data_req, data_wr, data_size, data_addr, data_wdata
   );

   modport slave (
      output mem_en, mem_wen, mem_addr, mem_wdata, mem_adv, flush,
      output data_addr_ok, data_data_ok, data_rdata,
      input  mem_rdata, mem_stall,
      input  data_req, data_wr, data_size, data_addr, data_wdata
   );
endinterface

// File: rtl/data_size_decode.sv
// Byte-enable to bus size decode; combinational, no backpressure.
// Patterns that are not word, aligned half or single byte report legal=0.
module data_size_decode
   import data_sram_bridge_pkg::*;
(
   input  logic [3:0] wen,
   output logic [1:0] size,
   output logic       legal
);

   always_comb begin
      size  = DATA_SIZE_WORD;
      legal = 1'b1;
      case (wen)
         4'b0000, 4'b1111:                   size = DATA_SIZE_WORD;
         4'b0011, 4'b1100:                   size = DATA_SIZE_HALF;
         4'b0001, 4'b0010, 4'b0100, 4'b1000: size = DATA_SIZE_BYTE;
         default: begin
            size  = DATA_SIZE_WORD;
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/data_sram_bridge.sv
// MEM-stage to SRAM-like bus bridge, one outstanding access; >=2 cycles mem_en to stall release,
// request held on the bus until addr_ok. Optional kseg address mapping under DATA_KSEG_MAP_EN.
module data_sram_bridge
   import data_sram_bridge_pkg::*;
(
   input logic                clk,
   input logic                rst,
   data_sram_bridge_if.master bus
);

   logic [1:0]  state, state_nxt;
   logic        cancel, cancel_nxt, cancel_eff;
   logic        capture, bypass, stall, load_buf;
   bus_req_t    req_q, req_nxt;
   logic [31:0] rbuf;
   logic [1:0]  dec_size;
   logic        dec_legal;

   data_size_decode u_size_decode (
      .wen   (bus.mem_wen),
      .size  (dec_size),
      .legal (dec_legal)
   );

   always_comb begin
      state_nxt  = state;
      cancel_eff = cancel | bus.flush;
      stall      = 1'b0;
      bypass     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.mem_en && !bus.flush) begin
               state_nxt = ST_ADDR;
               stall     = 1'b1;
            end
         end
         ST_ADDR: begin
            stall = 1'b1;
            if (bus.data_addr_ok) begin
               if (bus.data_data_ok) state_nxt = cancel_eff ? ST_IDLE : ST_DONE;
               else                  state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            stall = 1'b1;
            if (bus.data_data_ok) begin
               state_nxt = cancel_eff ? ST_IDLE : ST_DONE;
               stall     = cancel_eff;
               bypass    = !cancel_eff;
            end
         end
         ST_DONE: begin
            if (bus.mem_adv || bus.flush) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign capture  = (state == ST_IDLE) && (state_nxt == ST_ADDR);
   assign load_buf = (state != ST_DONE) && (state_nxt == ST_DONE);

   // The request is never retracted on flush; the flag only suppresses the result.
   always_comb begin
      cancel_nxt = cancel;
      if (state_nxt == ST_IDLE)
         cancel_nxt = 1'b0;
      else if ((state == ST_ADDR || state == ST_DATA) && bus.flush)
         cancel_nxt = 1'b1;
   end

   always_comb begin
      req_nxt.wr    = (|bus.mem_wen) && dec_legal;
      req_nxt.size  = dec_size;
      req_nxt.wdata = bus.mem_wdata;
`ifdef DATA_KSEG_MAP_EN
      req_nxt.addr  = kseg_map(bus.mem_addr);
`else
      req_nxt.addr  = bus.mem_addr;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         cancel <= 1'b0;
         req_q  <= '0;
         rbuf   <= '0;
      end else begin
         state  <= state_nxt;
         cancel <= cancel_nxt;
         if (capture)  req_q <= req_nxt;
         if (load_buf) rbuf  <= bus.data_rdata;
      end
   end

   assign bus.data_req   = (state == ST_ADDR);
   assign bus.data_wr    = req_q.wr;
   assign bus.data_size  = req_q.size;
   assign bus.data_addr  = req_q.addr;
   assign bus.data_wdata = req_q.wdata;

   assign bus.mem_stall = stall && !rst;
   assign bus.mem_rdata = rst                 ? 32'd0 :
                          bypass              ? bus.data_rdata :
                          (state == ST_DONE)  ? rbuf : 32'd0;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed bench for data_sram_bridge; kseg expectations follow DATA_KSEG_MAP_EN.
module tb_data_sram_bridge;

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   data_sram_bridge_if bus ();

   data_sram_bridge dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // from ADDR: accept address and data together, then let MEM advance out of DONE
   task automatic finish_txn();
      bus.data_addr_ok = 1'b1;
      bus.data_data_ok = 1'b1;
      step();
      bus.data_addr_ok = 1'b0;
      bus.data_data_ok = 1'b0;
      bus.mem_en       = 1'b0;
      bus.mem_adv      = 1'b1;
      step();
      bus.mem_adv      = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.mem_en = 1'b1;
      step();
      step();
      tests++; if (bus.data_req !== 1'b0) begin fails++; $display("FAIL rst_req got %0h want 0", bus.data_req); end
      tests++; if (bus.mem_stall !== 1'b0) begin fails++; $display("FAIL rst_stall got %0h want 0", bus.mem_stall); end
      tests++; if (bus.data_addr !== 32'd0 || bus.data_wdata !== 32'd0) begin fails++; $display("FAIL rst_addr_wdata got %h/%h want 0/0", bus.data_addr, bus.data_wdata); end
      tests++; if (bus.data_size !== 2'd0 || bus.data_wr !== 1'b0) begin fails++; $display("FAIL rst_size_wr got %0d/%0d want 0/0", bus.data_size, bus.data_wr); end
      tests++; if (bus.mem_rdata !== 32'd0) begin fails++; $display("FAIL rst_rdata got %h want 0", bus.mem_rdata); end
      bus.mem_en = 1'b0;
      rst = 1'b0;
      step();
   endtask

   task automatic test_load();
      bus.mem_en = 1'b1; bus.mem_wen = 4'b0000; bus.mem_addr = 32'h0000_0104; bus.mem_wdata = 32'd0;
      #1;
      tests++; if (bus.mem_stall !== 1'b1) begin fails++; $display("FAIL load_idle_stall got %0h want 1", bus.mem_stall); end
      step();
      tests++; if (bus.data_req !== 1'b1 || bus.data_wr !== 1'b0) begin fails++; $display("FAIL load_req got req=%0h wr=%0h want 1/0", bus.data_req, bus.data_wr); end
      tests++; if (bus.data_size !== 2'd2 || bus.data_addr !== 32'h0000_0104) begin fails++; $display("FAIL load_bus got size=%0d addr=%h want 2/00000104", bus.data_size, bus.data_addr); end
      tests++; if (bus.mem_rdata !== 32'd0 || bus.mem_stall !== 1'b1) begin fails++; $display("FAIL load_addr_out got rdata=%h stall=%0h want 0/1", bus.mem_rdata, bus.mem_stall); end
      bus.data_addr_ok = 1'b1;
      step();
      bus.data_addr_ok = 1'b0;
      tests++; if (bus.data_req !== 1'b0 || bus.mem_stall !== 1'b1 || bus.mem_rdata !== 32'd0) begin fails++; $display("FAIL load_data_wait got req=%0h stall=%0h rdata=%h want 0/1/0", bus.data_req, bus.mem_stall, bus.mem_rdata); end
      bus.data_data_ok = 1'b1; bus.data_rdata = 32'hDEAD_BEEF;
      #1;
      tests++; if (bus.mem_rdata !== 32'hDEAD_BEEF || bus.mem_stall !== 1'b0) begin fails++; $display("FAIL load_bypass got rdata=%h stall=%0h want deadbeef/0", bus.mem_rdata, bus.mem_stall); end
      step();
      bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0; bus.mem_en = 1'b0; bus.mem_adv = 1'b1;
      #1;
      tests++; if (bus.mem_rdata !== 32'hDEAD_BEEF || bus.mem_stall !== 1'b0) begin fails++; $display("FAIL load_done got rdata=%h stall=%0h want deadbeef/0", bus.mem_rdata, bus.mem_stall); end
      step();
      bus.mem_adv = 1'b0;
      tests++; if (bus.mem_rdata !== 32'd0 || bus.data_req !== 1'b0) begin fails++; $display("FAIL load_idle_after got rdata=%h req=%0h want 0/0", bus.mem_rdata, bus.data_req); end
   endtask

   task automatic test_store_byte();
      bus.mem_en = 1'b1; bus.mem_wen = 4'b0100; bus.mem_addr = 32'h0000_0012; bus.mem_wdata = 32'h5555_5555;
      step();
      tests++; if (bus.data_req !== 1'b1 || bus.data_wr !== 1'b1 || bus.data_size !== 2'd0) begin fails++; $display("FAIL store_ctl got req=%0h wr=%0h size=%0d want 1/1/0", bus.data_req, bus.data_wr, bus.data_size); end
      tests++; if (bus.data_addr !== 32'h0000_0012 || bus.data_wdata !== 32'h5555_5555) begin fails++; $display("FAIL store_bus got addr=%h wdata=%h want 00000012/55555555", bus.data_addr, bus.data_wdata); end
      bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1;
      step();
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
      tests++; if (bus.mem_stall !== 1'b0 || bus.data_req !== 1'b0) begin fails++; $display("FAIL store_same_cycle_done got stall=%0h req=%0h want 0/0", bus.mem_stall, bus.data_req); end
      bus.mem_en = 1'b0; bus.mem_adv = 1'b1;
      step();
      bus.mem_adv = 1'b0; bus.mem_wen = 4'b0000;
   endtask

   task automatic test_size_decode();
      logic [3:0] wen_v [8];
      logic [1:0] size_e[8];
      logic       wr_e  [8];
      wen_v = '{4'b0000, 4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b1000, 4'b0101, 4'b0111};
      size_e = '{2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd2, 2'd2};
      wr_e   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 8; i++) begin
         bus.mem_en = 1'b1; bus.mem_wen = wen_v[i]; bus.mem_addr = 32'h0000_0020;
         step();
         tests++; if (bus.data_size !== size_e[i] || bus.data_wr !== wr_e[i]) begin fails++; $display("FAIL size_decode wen=%b got size=%0d wr=%0h want %0d/%0h", wen_v[i], bus.data_size, bus.data_wr, size_e[i], wr_e[i]); end
         finish_txn();
      end
      bus.mem_wen = 4'b0000;
   endtask

   task automatic test_hold_done();
      bus.mem_en = 1'b1; bus.mem_wen = 4'b0000; bus.mem_addr = 32'h0000_0200;
      step();
      bus.data_addr_ok = 1'b1;
      step();
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'hA5A5_0F0F;
      step();
      bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0;
      for (int i = 0; i < 3; i++) begin
         tests++; if (bus.data_req !== 1'b0 || bus.mem_rdata !== 32'hA5A5_0F0F || bus.mem_stall !== 1'b0) begin fails++; $display("FAIL hold_done[%0d] got req=%0h rdata=%h stall=%0h want 0/a5a50f0f/0", i, bus.data_req, bus.mem_rdata, bus.mem_stall); end
         step();
      end
      bus.mem_en = 1'b0; bus.mem_adv = 1'b1;
      step();
      bus.mem_adv = 1'b0;
   endtask

   task automatic test_flush_data();
      bus.mem_en = 1'b1; bus.mem_wen = 4'b0000; bus.mem_addr = 32'h0000_0300;
      step();
      bus.data_addr_ok = 1'b1;
      step();
      bus.data_addr_ok = 1'b0; bus.flush = 1'b1; bus.mem_en = 1'b0;
      #1;
      tests++; if (bus.mem_stall !== 1'b1) begin fails++; $display("FAIL flush_stall0 got %0h want 1", bus.mem_stall); end
      step();
      bus.flush = 1'b0;
      tests++; if (bus.mem_stall !== 1'b1 || bus.data_req !== 1'b0) begin fails++; $display("FAIL flush_stall1 got stall=%0h req=%0h want 1/0", bus.mem_stall, bus.data_req); end
      bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1234_5678;
      #1;
      tests++; if (bus.mem_stall !== 1'b1) begin fails++; $display("FAIL flush_dataok_stall got %0h want 1", bus.mem_stall); end
      step();
      bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0;
      tests++; if (bus.mem_rdata !== 32'd0 || bus.mem_stall !== 1'b0) begin fails++; $display("FAIL flush_idle got rdata=%h stall=%0h want 0/0", bus.mem_rdata, bus.mem_stall); end
      bus.mem_en = 1'b1; bus.mem_addr = 32'h0000_0400;
      #1;
      tests++; if (bus.mem_stall !== 1'b1) begin fails++; $display("FAIL flush_no_done got stall=%0h want 1", bus.mem_stall); end
      step();
      tests++; if (bus.data_req !== 1'b1 || bus.data_addr !== 32'h0000_0400) begin fails++; $display("FAIL flush_next_req got req=%0h addr=%h want 1/00000400", bus.data_req, bus.data_addr); end
      bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h0BAD_CAFE;
      step();
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0;
      tests++; if (bus.mem_stall !== 1'b0 || bus.mem_rdata !== 32'h0BAD_CAFE) begin fails++; $display("FAIL flush_cancel_cleared got stall=%0h rdata=%h want 0/0badcafe", bus.mem_stall, bus.mem_rdata); end
      bus.mem_en = 1'b0; bus.mem_adv = 1'b1;
      step();
      bus.mem_adv = 1'b0;
   endtask

   task automatic test_backpressure();
      bus.mem_en = 1'b1; bus.mem_wen = 4'b1111; bus.mem_addr = 32'h1000_0040; bus.mem_wdata = 32'hCAFE_F00D;
      step();
      bus.mem_addr = 32'h0000_0999; bus.mem_wdata = 32'h1111_2222; bus.mem_wen = 4'b0001;
      for (int i = 0; i < 4; i++) begin
         tests++; if (bus.data_req !== 1'b1 || bus.data_addr !== 32'h1000_0040 || bus.data_wdata !== 32'hCAFE_F00D || bus.mem_stall !== 1'b1) begin fails++; $display("FAIL backpressure[%0d] got req=%0h addr=%h wdata=%h stall=%0h want 1/10000040/cafef00d/1", i, bus.data_req, bus.data_addr, bus.data_wdata, bus.mem_stall); end
         step();
      end
      tests++; if (bus.data_req !== 1'b1 || bus.data_size !== 2'd2 || bus.data_wr !== 1'b1) begin fails++; $display("FAIL backpressure_ctl got req=%0h size=%0d wr=%0h want 1/2/1", bus.data_req, bus.data_size, bus.data_wr); end
      finish_txn();
      bus.mem_wen = 4'b0000;
   endtask

   task automatic test_kseg();
      logic [31:0] va[3];
      logic [31:0] pa[3];
      va = '{32'hBFC0_0000, 32'h9000_0010, 32'hC000_0004};
`ifdef DATA_KSEG_MAP_EN
      pa = '{32'h1FC0_0000, 32'h1000_0010, 32'hC000_0004};
`else
      pa = '{32'hBFC0_0000, 32'h9000_0010, 32'hC000_0004};
`endif
      for (int i = 0; i < 3; i++) begin
         bus.mem_en = 1'b1; bus.mem_wen = 4'b0000; bus.mem_addr = va[i];
         step();
         tests++; if (bus.data_addr !== pa[i]) begin fails++; $display("FAIL kseg va=%h got %h want %h", va[i], bus.data_addr, pa[i]); end
         finish_txn();
      end
   endtask

   task automatic test_reset_mid();
      bus.mem_en = 1'b1; bus.mem_addr = 32'h0000_0500;
      step();
      #2 rst = 1'b1;
      #1;
      tests++; if (bus.data_req !== 1'b0 || bus.mem_stall !== 1'b0 || bus.data_addr !== 32'd0) begin fails++; $display("FAIL reset_mid got req=%0h stall=%0h addr=%h want 0/0/0", bus.data_req, bus.mem_stall, bus.data_addr); end
      bus.mem_en = 1'b0;
      step();
      rst = 1'b0;
      step();
      tests++; if (bus.data_req !== 1'b0 || bus.mem_stall !== 1'b0) begin fails++; $display("FAIL reset_mid_after got req=%0h stall=%0h want 0/0", bus.data_req, bus.mem_stall); end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1;
      bus.mem_en = 1'b0; bus.mem_wen = 4'b0000; bus.mem_addr = 32'd0; bus.mem_wdata = 32'd0;
      bus.mem_adv = 1'b0; bus.flush = 1'b0;
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0;
      test_reset();
      test_load();
      test_store_byte();
      test_size_decode();
      test_hold_done();
      test_flush_data();
      test_backpressure();
      test_kseg();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
